adc_convert_scheduler: RTL and testbench

//  Generates the single-cycle convert strobe for subsystem_adc. Triggers come from an internal

---
 rtl/adc_convert_scheduler.sv | 137 +++++++++++++
 tb/tb_adc_convert_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_convert_scheduler.sv
// adc_convert_scheduler: issues the single-cycle convert strobe for subsystem_adc from an
// internal period timer or an external trigger edge, in continuous or burst mode.
//
// state | meaning
// IDLE  | waiting for a rising edge of enable
// RUN   | generating ticks; convert issued on tick when convert_ready
// DONE  | one-cycle burst-complete pulse, then back to IDLE
module adc_convert_scheduler #(
  parameter int PERIOD_W = 32,
  parameter int BURST_W  = 16,
  parameter int MISS_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                burst_mode,
  input  logic                trig_src,
  input  logic [PERIOD_W-1:0] period,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic                ext_trig,
  input  logic                clear_counters,
  input  logic [63:0]         in_ts,
  input  logic                convert_ready,
  output logic                convert,
  output logic [63:0]         trig_ts,
  output logic [31:0]         seq_num,
  output logic                busy,
  output logic                done,
  output logic [MISS_W-1:0]   missed_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] timer, period_q, period_eff;
  logic [BURST_W-1:0]  burst_cnt, burst_eff;
  logic                enable_q, ext_q;
  logic                enable_rise, ext_rise, tick_int, tick, start;

  // Period below 2 would make back-to-back strobes possible, so clamp it.
  assign period_eff  = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
  assign burst_eff   = (burst_len == '0) ? BURST_W'(1) : burst_len;
  assign enable_rise = enable & ~enable_q;
  assign ext_rise    = ext_trig & ~ext_q;
  assign tick_int    = (timer == period_q - PERIOD_W'(1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register plus edge-detect history of enable and ext_trig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      enable_q <= enable;
      ext_q    <= ext_trig;
    end
  end

  // Next-state and tick qualification; leaving RUN suppresses any coinciding tick.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (enable_rise) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN: begin
        if (!enable)
          state_nxt = IDLE;
        else if (burst_mode && (burst_cnt >= burst_eff))
          state_nxt = DONE;
        else
          tick = trig_src ? ext_rise : tick_int;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Period timer; the period is latched only at (re)load so a change applies after the current tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      period_q <= '0;
    end else if (start || (state == RUN && tick_int)) begin
      timer    <= '0;
      period_q <= period_eff;
    end else if (state == RUN) begin
      timer    <= timer + PERIOD_W'(1);
    end
  end

  // Convert strobe, registered one cycle after the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) convert <= 1'b0;
    else        convert <= tick & convert_ready;
  end

  // Bookkeeping done in the strobe cycle: timestamp, sequence number, burst count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_ts   <= '0;
      seq_num   <= '0;
      burst_cnt <= '0;
    end else begin
      if (convert)
        trig_ts <= in_ts;
      if (clear_counters || start)
        seq_num <= '0;
      else if (convert)
        seq_num <= seq_num + 32'd1;
      if (start)
        burst_cnt <= '0;
      else if (convert)
        burst_cnt <= burst_cnt + BURST_W'(1);
    end
  end

  // Saturating count of ticks dropped because the deserializer was not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      missed_count <= '0;
    else if (clear_counters)
      missed_count <= '0;
    else if (tick && !convert_ready && (missed_count != '1))
      missed_count <= missed_count + MISS_W'(1);
  end

endmodule

// File: tb/tb_adc_convert_scheduler.sv
// Directed bench for adc_convert_scheduler with hand-computed strobe timing.
module tb_adc_convert_scheduler;

  localparam logic [63:0] TS_BASE = 64'h1234_5678_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, burst_mode, trig_src, ext_trig, clear_counters, convert_ready;
  logic [31:0] period;
  logic [15:0] burst_len;
  logic [63:0] in_ts;
  logic        convert, busy, done;
  logic [63:0] trig_ts;
  logic [31:0] seq_num;
  logic [15:0] missed_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int e;
  logic prev_conv = 1'b0;
  int conv_cyc[$];
  int done_cyc[$];
  int exp_q[$];

  adc_convert_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .burst_mode(burst_mode),
    .trig_src(trig_src), .period(period), .burst_len(burst_len), .ext_trig(ext_trig),
    .clear_counters(clear_counters), .in_ts(in_ts), .convert_ready(convert_ready),
    .convert(convert), .trig_ts(trig_ts), .seq_num(seq_num), .busy(busy),
    .done(done), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; inputs set after this return apply to cycle cyc.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    in_ts = TS_BASE + 64'(cyc);
    if (convert) begin
      if (prev_conv) chk("no_back2back", 1, 0);
      conv_cyc.push_back(cyc);
    end
    prev_conv = convert;
    if (done) done_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) step();
  endtask

  task automatic start_run();
    conv_cyc.delete();
    done_cyc.delete();
    enable = 1'b1;
    e = cyc;
  endtask

  task automatic check_convs(input string tag);
    chk({tag, "_count"}, 64'(conv_cyc.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < conv_cyc.size(); i++)
      chk({tag, "_when"}, 64'(conv_cyc[i] - e), 64'(exp_q[i]));
  endtask

  initial begin
    rst_n = 1'b0; enable = 0; burst_mode = 0; trig_src = 0; ext_trig = 0;
    clear_counters = 0; convert_ready = 1; period = 32'd10; burst_len = 16'd4;
    in_ts = TS_BASE;
    #1;
    chk("rst_convert", 64'(convert), 0);
    chk("rst_trig_ts", trig_ts, 0);
    chk("rst_seq", 64'(seq_num), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_missed", 64'(missed_count), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // continuous, period 10
    start_run();
    step();
    chk("t1_busy", 64'(busy), 1);
    repeat (44) step();
    exp_q = '{11, 21, 31, 41};
    check_convs("t1");
    chk("t1_seq", 64'(seq_num), 4);
    chk("t1_trig_ts", trig_ts, TS_BASE + 64'(e + 41));

    // burst of 4, period 5, enable held afterwards
    idle(3);
    burst_mode = 1; burst_len = 16'd4; period = 32'd5;
    start_run();
    repeat (40) step();
    exp_q = '{6, 11, 16, 21};
    check_convs("t2");
    chk("t2_done_count", 64'(done_cyc.size()), 1);
    if (done_cyc.size() > 0) chk("t2_done_when", 64'(done_cyc[0] - e), 23);
    chk("t2_busy_end", 64'(busy), 0);
    chk("t2_seq", 64'(seq_num), 4);

    // three missed ticks, then a convert
    idle(3);
    burst_mode = 0; period = 32'd8; convert_ready = 0;
    start_run();
    for (int i = 0; i < 34; i++) begin
      step();
      if (cyc == e + 28) convert_ready = 1;
    end
    chk("t3_missed", 64'(missed_count), 3);
    chk("t3_seq", 64'(seq_num), 1);
    chk("t3_trig_ts", trig_ts, TS_BASE + 64'(e + 33));

    // clear during a miss (tick at e+40)
    while (cyc < e + 40) step();
    convert_ready = 0; clear_counters = 1;
    step();
    chk("t4_missed_clr", 64'(missed_count), 0);
    chk("t4_seq_clr", 64'(seq_num), 0);
    chk("t4_no_convert", 64'(convert), 0);
    clear_counters = 0; convert_ready = 1;

    // enable dropped exactly on the tick at e+48
    while (cyc < e + 48) step();
    enable = 0;
    step();
    chk("t5_no_convert", 64'(convert), 0);
    chk("t5_busy", 64'(busy), 0);
    repeat (3) step();
    exp_q = '{33};
    check_convs("t3_5");

    // period 0 and 1 behave as 2
    period = 32'd0;
    start_run();
    repeat (8) step();
    exp_q = '{3, 5, 7};
    check_convs("t6_p0");
    idle(3);
    period = 32'd1;
    start_run();
    repeat (8) step();
    check_convs("t6_p1");

    // burst_len 0 behaves as 1
    idle(3);
    period = 32'd3; burst_mode = 1; burst_len = 16'd0;
    start_run();
    repeat (10) step();
    exp_q = '{4};
    check_convs("t7");
    chk("t7_done_count", 64'(done_cyc.size()), 1);
    if (done_cyc.size() > 0) chk("t7_done_when", 64'(done_cyc[0] - e), 6);

    // external trigger edges
    idle(3);
    burst_mode = 0; trig_src = 1; period = 32'd3;
    start_run();
    for (int i = 0; i < 16; i++) begin
      step();
      if (cyc == e + 3)  ext_trig = 1;
      if (cyc == e + 8)  ext_trig = 0;
      if (cyc == e + 10) ext_trig = 1;
    end
    exp_q = '{4, 11};
    check_convs("t8");
    chk("t8_seq", 64'(seq_num), 2);
    ext_trig = 0; trig_src = 0;

    // reset in the middle of a burst
    idle(3);
    burst_mode = 1; burst_len = 16'd5; period = 32'd4;
    start_run();
    while (cyc < e + 10) step();
    chk("t9_seq_before", 64'(seq_num), 2);
    rst_n = 1'b0;
    #1;
    chk("t9_convert", 64'(convert), 0);
    chk("t9_trig_ts", trig_ts, 0);
    chk("t9_seq", 64'(seq_num), 0);
    chk("t9_busy", 64'(busy), 0);
    chk("t9_done", 64'(done), 0);
    chk("t9_missed", 64'(missed_count), 0);
    enable = 0;
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("t9_no_done", 64'(done_cyc.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
